dspl_scan_capture: RTL

- Reader for the 8-digit multiplexed seven-segment bus (AN/DIGIT) produced by the display driver.
- Watches the anode scan and the segment lines, and decodes each lit digit back into the 6-bit digit code used by the watch logic: {enable, hex[3:0], dp}.
- Publishes a coherent d1..d8 snapshot once per scan frame.
- Used for on-board loopback self-check and as the scoreboard front-end in clock/display benches.

---
 rtl/dspl_scan_capture.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dspl_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : dspl_scan_capture
// Purpose  : Reader for the 8-digit multiplexed seven-segment bus (AN/DIGIT).
//            Filters the anode scan for stability, decodes each lit digit back
//            into the 6-bit code {en, hex[3:0], dp} and publishes a coherent
//            d1..d8 snapshot once per scan frame (or an all-blank snapshot
//            after a scan timeout).
// Options  : SCAN_CAPTURE_DP_EN - when defined, the decimal point segment is
//            decoded into the dp bit; otherwise digit_i[0] is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dspl_scan_capture #(
   parameter int STABLE_CYCLES = 16,
   parameter int FRAME_TIMEOUT = 400000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] an_i,
   input  logic [7:0] digit_i,
   output logic [5:0] d1_o,
   output logic [5:0] d2_o,
   output logic [5:0] d3_o,
   output logic [5:0] d4_o,
   output logic [5:0] d5_o,
   output logic [5:0] d6_o,
   output logic [5:0] d7_o,
   output logic [5:0] d8_o,
   output logic       frame_valid_o,
   output logic       pattern_err_o,
   output logic [7:0] err_cnt_o
);

   localparam int C_STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int C_TO_W   = $clog2(FRAME_TIMEOUT);

   localparam logic [C_STAB_W-1:0] C_STAB_MAX  = C_STAB_W'(STABLE_CYCLES);
   localparam logic [C_STAB_W-1:0] C_STAB_FIRE = C_STAB_W'(STABLE_CYCLES - 1);
   localparam logic [C_TO_W-1:0]   C_TO_LAST   = C_TO_W'(FRAME_TIMEOUT - 1);

`ifdef SCAN_CAPTURE_DP_EN
   localparam int C_DIG_LSB = 0;
`else
   localparam int C_DIG_LSB = 1;
`endif

   // ------------------------------------------------------------------------
   // Input registers: one capture stage plus a one-cycle-old copy for the
   // change detector.
   // ------------------------------------------------------------------------
   logic [7:0]         an_r_q,  an_r_d;
   logic [7:0]         an_p_q,  an_p_d;
   logic [7:C_DIG_LSB] dig_r_q, dig_r_d;
   logic [7:C_DIG_LSB] dig_p_q, dig_p_d;

`ifndef SCAN_CAPTURE_DP_EN
   // The dp segment line has no function in this build.
   logic unused_dp;
   assign unused_dp = digit_i[0];
`endif

   // Next values of the input pipeline.
   always_comb begin
      an_r_d  = an_i;
      dig_r_d = digit_i[7:C_DIG_LSB];
      an_p_d  = an_r_q;
      dig_p_d = dig_r_q;
   end

   // Input pipeline registers; idle (all lines high) after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         an_r_q  <= 8'hFF;
         an_p_q  <= 8'hFF;
         dig_r_q <= '1;
         dig_p_q <= '1;
      end else begin
         an_r_q  <= an_r_d;
         an_p_q  <= an_p_d;
         dig_r_q <= dig_r_d;
         dig_p_q <= dig_p_d;
      end
   end

   // ------------------------------------------------------------------------
   // Stability filter: count unchanged cycles, fire exactly once per steady
   // period. Saturating one above the fire value keeps it from re-firing.
   // ------------------------------------------------------------------------
   logic [C_STAB_W-1:0] stab_cnt_q, stab_cnt_d;
   logic                changed;
   logic                fire;

   // Change detection and stability count.
   always_comb begin
      changed = (an_r_q != an_p_q) || (dig_r_q != dig_p_q);
      if (changed) begin
         stab_cnt_d = '0;
      end else if (stab_cnt_q == C_STAB_MAX) begin
         stab_cnt_d = stab_cnt_q;
      end else begin
         stab_cnt_d = stab_cnt_q + C_STAB_W'(1);
      end
      fire = (stab_cnt_q == C_STAB_FIRE);
   end

   // Stability counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stab_cnt_q <= '0;
      end else begin
         stab_cnt_q <= stab_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Anode classification: blank, single digit (with index) or illegal.
   // ------------------------------------------------------------------------
   logic [7:0] an_low;
   logic       an_blank;
   logic       an_onehot;
   logic [2:0] an_idx;

   // Decode the steady anode pattern into a digit index.
   always_comb begin
      an_low    = ~an_p_q;
      an_blank  = (an_p_q == 8'hFF);
      an_onehot = !an_blank && ((an_low & (an_low - 8'd1)) == 8'd0);
      an_idx    = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (an_low[i]) begin
            an_idx = 3'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Segment decode, active-low a..g on digit bits [7:1].
   // ------------------------------------------------------------------------
   logic [3:0] seg_hex;
   logic       seg_ok;
   logic       dp_bit;

   // Map the seven segment lines back to a hex value.
   always_comb begin
      seg_ok  = 1'b1;
      seg_hex = 4'h0;
      case (dig_p_q[7:1])
         7'h01:   seg_hex = 4'h0;
         7'h4F:   seg_hex = 4'h1;
         7'h12:   seg_hex = 4'h2;
         7'h06:   seg_hex = 4'h3;
         7'h4C:   seg_hex = 4'h4;
         7'h24:   seg_hex = 4'h5;
         7'h20:   seg_hex = 4'h6;
         7'h0F:   seg_hex = 4'h7;
         7'h00:   seg_hex = 4'h8;
         7'h04:   seg_hex = 4'h9;
         7'h08:   seg_hex = 4'hA;
         7'h60:   seg_hex = 4'hB;
         7'h31:   seg_hex = 4'hC;
         7'h42:   seg_hex = 4'hD;
         7'h30:   seg_hex = 4'hE;
         7'h38:   seg_hex = 4'hF;
         default: seg_ok  = 1'b0;
      endcase
   end

`ifdef SCAN_CAPTURE_DP_EN
   assign dp_bit = ~dig_p_q[0];
`else
   assign dp_bit = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Capture events and frame boundary control.
   // ------------------------------------------------------------------------
   logic [2:0]        last_q,   last_d;
   logic [C_TO_W-1:0] to_cnt_q, to_cnt_d;
   logic              fv_q,     fv_d;
   logic              perr_q,   perr_d;
   logic [7:0]        err_q,    err_d;
   logic              legal;
   logic              err_ev;
   logic              wrap;
   logic              timeout;
   logic              publish;
   logic [5:0]        new_code;

   // Classify the fired sample and derive wrap/timeout/publish.
   always_comb begin
      legal    = fire && an_onehot && seg_ok;
      err_ev   = fire && !an_blank && !(an_onehot && seg_ok);
      wrap     = legal && (an_idx <= last_q);
      timeout  = !legal && (to_cnt_q == C_TO_LAST);
      publish  = wrap || timeout;
      new_code = {1'b1, seg_hex, dp_bit};

      last_d   = legal ? an_idx : last_q;
      to_cnt_d = (legal || timeout) ? '0 : (to_cnt_q + C_TO_W'(1));
      fv_d     = publish;
      perr_d   = err_ev;
      err_d    = (err_ev && (err_q != 8'hFF)) ? (err_q + 8'd1) : err_q;
   end

   // Control registers; last index starts at 7 so the first capture wraps.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q   <= 3'd7;
         to_cnt_q <= '0;
         fv_q     <= 1'b0;
         perr_q   <= 1'b0;
         err_q    <= 8'd0;
      end else begin
         last_q   <= last_d;
         to_cnt_q <= to_cnt_d;
         fv_q     <= fv_d;
         perr_q   <= perr_d;
         err_q    <= err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Per-digit shadow slot, seen flag and published output.
   // A wrap publishes the old shadow before the new capture lands in it.
   // ------------------------------------------------------------------------
   logic [47:0] out_bus;

   for (genvar k = 0; k < 8; k++) begin : g_slot
      logic [5:0] shadow_q, shadow_d;
      logic [5:0] out_q,    out_d;
      logic       seen_q,   seen_d;
      logic       hit;

      // Slot update: store on a hit, publish on wrap, blank on timeout.
      always_comb begin
         hit      = legal && (an_idx == 3'(k));
         shadow_d = hit ? new_code : shadow_q;
         seen_d   = (publish ? 1'b0 : seen_q) | hit;
         if (wrap) begin
            out_d = seen_q ? shadow_q : 6'd0;
         end else if (timeout) begin
            out_d = 6'd0;
         end else begin
            out_d = out_q;
         end
      end

      // Slot registers.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            shadow_q <= 6'd0;
            out_q    <= 6'd0;
            seen_q   <= 1'b0;
         end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
            seen_q   <= seen_d;
         end
      end

      assign out_bus[k*6 +: 6] = out_q;
   end

   assign d1_o          = out_bus[5:0];
   assign d2_o          = out_bus[11:6];
   assign d3_o          = out_bus[17:12];
   assign d4_o          = out_bus[23:18];
   assign d5_o          = out_bus[29:24];
   assign d6_o          = out_bus[35:30];
   assign d7_o          = out_bus[41:36];
   assign d8_o          = out_bus[47:42];
   assign frame_valid_o = fv_q;
   assign pattern_err_o = perr_q;
   assign err_cnt_o     = err_q;

endmodule
`default_nettype wire
